// File: rtl/hash_fill_ctrl.sv
// Producer side of the HASH BRAM ping-pong buffer. Streams generator words into
// two alternating banks, tracks how many banks hold a complete block, and hands
// full banks to the consumer one at a time.
module hash_fill_ctrl #(
    parameter int unsigned WORDS_PER_BLOCK = 1344,
    parameter int unsigned NUM_BLOCKS      = 336,
    parameter logic [31:0] BANK_STRIDE     = 32'd8192
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        gen_valid,
    input  logic [63:0] gen_data,
    output logic        gen_ready,
    input  logic        consume_done,
    output logic [31:0] addr_HASH_w,
    output logic [63:0] data_HASH_w,
    output logic        wen_HASH_w,
    output logic        HASH_ready,
    output logic        rd_bank,
    output logic        busy,
    output logic        done,
    output logic        err_underflow,
    output logic [1:0]  current_state
);

    localparam int unsigned WcW = (WORDS_PER_BLOCK > 1) ? $clog2(WORDS_PER_BLOCK) : 1;
    localparam int unsigned BcW = $clog2(NUM_BLOCKS + 1);
    localparam logic [WcW-1:0] LastWord = WcW'(WORDS_PER_BLOCK - 1);
    localparam logic [BcW-1:0] LastBlk  = BcW'(NUM_BLOCKS - 1);

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StFill  = 2'd1,
        StDrain = 2'd2,
        StFin   = 2'd3
    } state_e;

    state_e         state_q, state_d;
    logic           wr_bank_q, wr_bank_d;
    logic           rd_bank_q, rd_bank_d;
    logic [WcW-1:0] word_cnt_q, word_cnt_d;
    logic [BcW-1:0] blk_cnt_q, blk_cnt_d;
    logic [1:0]     full_cnt_q, full_cnt_d;
    logic           hash_ready_q, hash_ready_d;
    logic           err_q, err_d;

    logic accept;
    logic block_end;
    logic consume_hit;

    assign accept      = gen_valid && gen_ready;
    assign block_end   = accept && (word_cnt_q == LastWord);
    // A release only counts when a bank is actually full; otherwise it is an underflow.
    assign consume_hit = (state_q != StIdle) && consume_done && (full_cnt_q != 2'd0);

    // State and datapath registers, synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            wr_bank_q    <= 1'b0;
            rd_bank_q    <= 1'b0;
            word_cnt_q   <= '0;
            blk_cnt_q    <= '0;
            full_cnt_q   <= 2'd0;
            hash_ready_q <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            wr_bank_q    <= wr_bank_d;
            rd_bank_q    <= rd_bank_d;
            word_cnt_q   <= word_cnt_d;
            blk_cnt_q    <= blk_cnt_d;
            full_cnt_q   <= full_cnt_d;
            hash_ready_q <= hash_ready_d;
            err_q        <= err_d;
        end
    end

    // FSM next-state
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (start) state_d = StFill;
            StFill:  if (block_end && (blk_cnt_q == LastBlk)) state_d = StDrain;
            StDrain: if (full_cnt_q == 2'd0) state_d = StFin;
            StFin:   state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Counter, bank pointer and flag next-state
    always_comb begin
        wr_bank_d  = wr_bank_q;
        rd_bank_d  = rd_bank_q;
        word_cnt_d = word_cnt_q;
        blk_cnt_d  = blk_cnt_q;
        full_cnt_d = full_cnt_q;
        err_d      = err_q;
        if (state_q == StIdle) begin
            if (start) begin
                wr_bank_d  = 1'b0;
                rd_bank_d  = 1'b0;
                word_cnt_d = '0;
                blk_cnt_d  = '0;
                full_cnt_d = 2'd0;
                err_d      = 1'b0;
            end
        end else begin
            if (block_end) begin
                word_cnt_d = '0;
                wr_bank_d  = ~wr_bank_q;
                blk_cnt_d  = blk_cnt_q + BcW'(1);
            end else if (accept) begin
                word_cnt_d = word_cnt_q + WcW'(1);
            end
            if (consume_hit) begin
                rd_bank_d = ~rd_bank_q;
            end
            if (consume_done && (full_cnt_q == 2'd0)) begin
                err_d = 1'b1;
            end
            // Simultaneous fill and release cancel out on the count.
            full_cnt_d = full_cnt_q + 2'(block_end) - 2'(consume_hit);
        end
        hash_ready_d = (full_cnt_d != 2'd0);
    end

    // FSM and write-port outputs
    always_comb begin
        gen_ready     = (state_q == StFill) && (full_cnt_q < 2'd2);
        busy          = (state_q != StIdle);
        done          = (state_q == StFin);
        current_state = state_q;
        wen_HASH_w    = gen_valid && gen_ready;
        addr_HASH_w   = (wr_bank_q ? BANK_STRIDE : 32'd0) + 32'(word_cnt_q);
        // Gated so the data bus is never X/garbage when no write is issued.
        data_HASH_w   = wen_HASH_w ? gen_data : 64'd0;
    end

    assign HASH_ready    = hash_ready_q;
    assign rd_bank       = rd_bank_q;
    assign err_underflow = err_q;

endmodule

// File: tb/tb_hash_fill_ctrl.sv
// Scoreboard bench for hash_fill_ctrl with 4-word blocks, 3 blocks per pass,
// bank stride 16.
module tb_hash_fill_ctrl;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        gen_valid;
    logic [63:0] gen_data;
    logic        gen_ready;
    logic        consume_done;
    logic [31:0] addr_HASH_w;
    logic [63:0] data_HASH_w;
    logic        wen_HASH_w;
    logic        HASH_ready;
    logic        rd_bank;
    logic        busy;
    logic        done;
    logic        err_underflow;
    logic [1:0]  current_state;

    int n_checks = 0;
    int n_fail   = 0;
    int wr_count = 0;
    int gen_idx  = 0;
    int push_idx = 0;

    logic [95:0] exp_q[$];

    hash_fill_ctrl #(
        .WORDS_PER_BLOCK(4),
        .NUM_BLOCKS     (3),
        .BANK_STRIDE    (32'd16)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .gen_valid    (gen_valid),
        .gen_data     (gen_data),
        .gen_ready    (gen_ready),
        .consume_done (consume_done),
        .addr_HASH_w  (addr_HASH_w),
        .data_HASH_w  (data_HASH_w),
        .wen_HASH_w   (wen_HASH_w),
        .HASH_ready   (HASH_ready),
        .rd_bank      (rd_bank),
        .busy         (busy),
        .done         (done),
        .err_underflow(err_underflow),
        .current_state(current_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [63:0] word_of(input int k);
        return {32'hC0DE_0000 + 32'(k), ~32'(k)};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Queue the next expected BRAM write at the given address.
    task automatic push(input logic [31:0] addr);
        exp_q.push_back({addr, word_of(push_idx)});
        push_idx++;
    endtask

    // Advance one clock; the generator moves to its next word after a handshake.
    task automatic step();
        logic fire;
        @(negedge clk);
        fire = gen_valid && gen_ready;
        @(posedge clk);
        #1;
        if (fire) begin
            gen_idx++;
            gen_data = word_of(gen_idx);
        end
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    // Release full banks as they appear until the pass completes.
    task automatic finish_pass();
        logic got;
        got = 1'b0;
        for (int c = 0; c < 60; c++) begin
            consume_done = HASH_ready;
            step();
            consume_done = 1'b0;
            if (done) begin
                got = 1'b1;
                break;
            end
        end
        check("pass_done_seen", 64'(got), 64'd1);
        step();
        check("idle_after_done", {62'd0, busy, done}, 64'd0);
    endtask

    // Monitor: every BRAM write must match the head of the expected queue.
    always @(negedge clk) begin
        if (wen_HASH_w) begin
            wr_count++;
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_write: got addr %h data %h, expected no write",
                         addr_HASH_w, data_HASH_w);
            end else begin
                logic [95:0] e;
                e = exp_q.pop_front();
                check("write_addr", 64'(addr_HASH_w), 64'(e[95:64]));
                check("write_data", data_HASH_w, e[63:0]);
            end
        end
    end

    initial begin
        int base;
        int delay;
        int acks;
        int extra_done;
        logic hr_prev;
        logic seen_drain;
        logic got;

        rst_n        = 1'b0;
        start        = 1'b0;
        gen_valid    = 1'b0;
        gen_data     = word_of(0);
        consume_done = 1'b0;
        steps(2);
        check("reset_flags", {56'd0, HASH_ready, gen_ready, busy, done, rd_bank,
                              err_underflow, current_state}, 64'd0);
        check("reset_addr", 64'(addr_HASH_w), 64'd0);
        check("reset_data_wen", data_HASH_w | 64'(wen_HASH_w), 64'd0);
        rst_n = 1'b1;
        step();

        // Fill both banks with no consumer acknowledgement.
        for (int a = 0; a < 4; a++) push(32'(a));
        for (int a = 16; a < 20; a++) push(32'(a));
        start     = 1'b1;
        gen_valid = 1'b1;
        step();
        start = 1'b0;
        check("fill_state", 64'(current_state), 64'd1);
        steps(3);
        check("hr_before_block_end", 64'(HASH_ready), 64'd0);
        step();
        check("hr_after_addr3", 64'(HASH_ready), 64'd1);
        steps(4);
        check("both_full_ready_wen", {62'd0, gen_ready, wen_HASH_w}, 64'd0);
        check("both_full_rd_bank", 64'(rd_bank), 64'd0);
        steps(2);

        // One release frees bank 0; the third block refills it.
        for (int a = 0; a < 4; a++) push(32'(a));
        consume_done = 1'b1;
        step();
        consume_done = 1'b0;
        check("release_rd_bank", 64'(rd_bank), 64'd1);
        check("release_gen_ready", 64'(gen_ready), 64'd1);
        check("resume_addr", {31'd0, wen_HASH_w, addr_HASH_w}, {31'd0, 1'b1, 32'd0});
        steps(4);
        check("drain_state", 64'(current_state), 64'd2);
        check("drain_gen_ready", 64'(gen_ready), 64'd0);
        gen_valid = 1'b0;
        finish_pass();

        // Full pass with the consumer acking two cycles after each HASH_ready rise.
        for (int a = 0; a < 4; a++) push(32'(a));
        for (int a = 16; a < 20; a++) push(32'(a));
        for (int a = 0; a < 4; a++) push(32'(a));
        base       = wr_count;
        delay      = 0;
        acks       = 0;
        hr_prev    = 1'b0;
        seen_drain = 1'b0;
        got        = 1'b0;
        start      = 1'b1;
        gen_valid  = 1'b1;
        step();
        start = 1'b0;
        for (int c = 0; c < 80; c++) begin
            consume_done = (delay == 1);
            if (consume_done) acks++;
            if (delay > 0) delay--;
            step();
            consume_done = 1'b0;
            if (HASH_ready && !hr_prev) delay = 2;
            hr_prev = HASH_ready;
            if (current_state == 2'd2 && !seen_drain) begin
                seen_drain = 1'b1;
                check("writes_at_drain", 64'(wr_count - base), 64'd12);
            end
            if (done) begin
                got = 1'b1;
                break;
            end
        end
        check("pass3_done_seen", 64'(got), 64'd1);
        check("pass3_acks_at_done", 64'(acks), 64'd3);
        gen_valid = 1'b0;
        step();
        check("pass3_busy_after", {62'd0, busy, done}, 64'd0);
        extra_done = 0;
        for (int i = 0; i < 4; i++) begin
            step();
            if (done) extra_done++;
        end
        check("pass3_single_done", 64'(extra_done), 64'd0);

        // Underflow, then a release coinciding with a block end.
        start = 1'b1;
        step();
        start        = 1'b0;
        consume_done = 1'b1;
        step();
        consume_done = 1'b0;
        check("underflow_set", 64'(err_underflow), 64'd1);
        check("underflow_rd_bank", 64'(rd_bank), 64'd0);
        for (int a = 0; a < 4; a++) push(32'(a));
        for (int a = 16; a < 20; a++) push(32'(a));
        for (int a = 0; a < 4; a++) push(32'(a));
        gen_valid = 1'b1;
        steps(4);
        check("coinc_hr_pre", 64'(HASH_ready), 64'd1);
        steps(3);
        consume_done = 1'b1;
        step();
        consume_done = 1'b0;
        check("coinc_hr", 64'(HASH_ready), 64'd1);
        check("coinc_rd_bank", 64'(rd_bank), 64'd1);
        check("coinc_gen_ready", 64'(gen_ready), 64'd1);
        check("coinc_wr_bank", {31'd0, wen_HASH_w, addr_HASH_w}, {31'd0, 1'b1, 32'd0});
        finish_pass();
        gen_valid = 1'b0;
        check("underflow_sticky", 64'(err_underflow), 64'd1);

        // Next start clears the error; reset mid-block aborts the pass.
        start = 1'b1;
        step();
        start = 1'b0;
        check("start_clears_err", 64'(err_underflow), 64'd0);
        push(32'd0);
        push(32'd1);
        gen_valid = 1'b1;
        steps(2);
        check("mid_block_addr", 64'(addr_HASH_w), 64'd2);
        rst_n     = 1'b0;
        gen_valid = 1'b0;
        step();
        check("midrst_flags", {56'd0, HASH_ready, gen_ready, busy, done, rd_bank,
                               err_underflow, current_state}, 64'd0);
        check("midrst_addr", 64'(addr_HASH_w), 64'd0);
        rst_n = 1'b1;
        for (int a = 0; a < 4; a++) push(32'(a));
        start     = 1'b1;
        gen_valid = 1'b1;
        step();
        start = 1'b0;
        steps(4);
        check("post_rst_hr", 64'(HASH_ready), 64'd1);
        gen_valid = 1'b0;
        rst_n     = 1'b0;
        step();
        check("queue_drained", 64'(exp_q.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
